// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative RV32M multiply/divide unit for the EX stage. One result bit per
//   cycle: radix-2 shift-add for multiplies and restoring division for
//   divides. Both run on operand magnitudes. The sign is applied when the
//   result is captured. Divide-by-zero and signed overflow skip the
//   iteration and go straight to DONE.
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   flush            abort the operation in progress (no done pulse)
//   start            EX holds a valid M-extension instruction
//   funct3           0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   op_a, op_b       dividend/multiplicand, divisor/multiplier
//   stall_req        freeze IF/ID/EX while the operation is in progress
//   done             one-cycle pulse, result valid this cycle
//   result           registered result, held until the next completion
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*XLEN-1:0]   acc_q;     // mul: {partial hi, multiplier}; div: {rem, quot}
    logic [XLEN-1:0]     opnd_q;    // mul: multiplicand magnitude; div: divisor magnitude
    logic [XLEN-1:0]     result_q;
    logic [2:0]          f3_q;
    logic                neg_q;

    // Operand decode at accept time
    logic            is_div, a_signed, b_signed, sa, sb, neg_in;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, fast, accept;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        is_div   = funct3[2];
        a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
        b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        sa       = a_signed & op_a[XLEN-1];
        sb       = b_signed & op_b[XLEN-1];
        mag_a    = sa ? -op_a : op_a;
        mag_b    = sb ? -op_b : op_b;
        // Remainder follows the dividend sign; products and quotients use sa^sb.
        neg_in   = (is_div && funct3[1]) ? sa : (sa ^ sb);
        div_zero = is_div && (op_b == '0);
        // Signed-only (DIV/REM have funct3[0]==0): most-negative / -1.
        div_ovf  = is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (op_b == {XLEN{1'b1}});
        fast     = div_zero || div_ovf;
        if (div_zero) begin
            fast_res = funct3[1] ? op_a : {XLEN{1'b1}};
        end else begin
            fast_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
        accept    = start && (state_q == S_IDLE) && !flush;
        stall_req = accept || (state_q == S_CALC);
        done      = (state_q == S_DONE);
    end

    // One iteration of the shared datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, div_next, step_next, mul_fix;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff, quot, rem, res_calc;

    always_comb begin
        // Shift-add: add multiplicand into the high half when the LSB is set,
        // then shift the whole accumulator right, carry included.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        // Restoring divide: shift {rem,quot} left, trial-subtract the divisor.
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_ge    = (div_shift >= {1'b0, opnd_q});
        // When div_ge holds the difference is below the divisor, so XLEN bits suffice.
        div_diff  = div_shift[XLEN-1:0] - opnd_q;
        div_next  = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                           : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        step_next = f3_q[2] ? div_next : mul_next;

        // Final sign fix-up, applied to the value captured on DONE entry.
        mul_fix = neg_q ? -step_next : step_next;
        quot    = neg_q ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
        rem     = neg_q ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];
        case (f3_q)
            3'd0:                res_calc = mul_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    res_calc = mul_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:          res_calc = quot;
            default:             res_calc = rem;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = fast ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush)              state_d = S_IDLE;
                else if (cnt_q == '0)   state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
        end else if (accept) begin
            cnt_q  <= CNT_W'(XLEN-1);
            f3_q   <= funct3;
            neg_q  <= neg_in;
            acc_q  <= is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
            opnd_q <= is_div ? mag_b : mag_a;
            if (fast) begin
                result_q <= fast_res;
            end
        end else if ((state_q == S_CALC) && !flush) begin
            acc_q <= step_next;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                result_q <= res_calc;
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall_req;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .start     (start),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model straight from the RV32M rules using wide arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] pu;
        longint      ps;
        int          ia, ib;
        ia = int'(a);
        ib = int'(b);
        case (f)
            3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
            3'd1: begin ps = longint'(ia) * longint'(ib); return ps[63:32]; end
            3'd2: begin ps = longint'(ia) * longint'({32'b0, b}); return ps[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            4: return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation; with sync_first=0 the caller is already inside cycle 0.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input bit sync_first);
        int cyc;
        bit got;
        bit stall_ok;
        string tag;
        tag = $sformatf("f3=%0d a=%h b=%h", f, a, b);
        if (sync_first) @(negedge clk);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        #1;
        chk({"accept_stall ", tag}, 32'(stall_req), 32'd1);
        cyc      = 0;
        got      = 1'b0;
        stall_ok = 1'b1;
        while (!got && cyc < 200) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            #1;
            if (done) got = 1'b1;
            else if (stall_req !== 1'b1) stall_ok = 1'b0;
        end
        chk({"done_seen ", tag}, 32'(got), 32'd1);
        chk({"latency ", tag}, 32'(cyc), 32'(exp_lat));
        chk({"result ", tag}, result, exp_res);
        chk({"stall_during ", tag}, 32'(stall_ok), 32'd1);
        chk({"stall_at_done ", tag}, 32'(stall_req), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        bit   saw_done;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
        tbl[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33};
        tbl[4]  = '{3'd5, 32'd100,        32'd0,         32'hFFFF_FFFF, 1};
        tbl[5]  = '{3'd6, 32'd100,        32'd0,         32'h0000_0064, 1};
        tbl[6]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[7]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
        tbl[8]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        tbl[9]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        tbl[10] = '{3'd5, 32'd9,          32'd3,         32'd3,         33};
        tbl[11] = '{3'd7, 32'h1234_5678,  32'h0000_1000, 32'h0000_0678, 33};
        tbl[12] = '{3'd1, 32'hFFFF_FFFF,  32'd5,         32'hFFFF_FFFF, 33};

        rst = 1'b1; flush = 1'b0; start = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_stall", 32'(stall_req), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 1'b1);
        end

        // Flush at cycle 10 of a DIVU, then a new start at cycle 11.
        do_op(3'd5, 32'd1000, 32'd7, 32'd142, 33, 1'b1);
        @(negedge clk);
        funct3 = 3'd5; op_a = 32'hFFFF_FFFF; op_b = 32'd3; start = 1'b1;
        #1;
        chk("flush_accept_stall", 32'(stall_req), 32'd1);
        saw_done = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 10) flush = 1'b1;
            #1;
            if (done) saw_done = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_no_done_before", 32'(saw_done), 32'd0);
        chk("flush_stall_c11", 32'(stall_req), 32'd0);
        chk("flush_done_c11", 32'(done), 32'd0);
        chk("flush_result_kept", result, 32'd142);
        do_op(3'd5, 32'd50, 32'd5, 32'd10, 33, 1'b0);

        // flush and start together: nothing accepted.
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4; start = 1'b1; flush = 1'b1;
        #1;
        chk("flush_start_stall", 32'(stall_req), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        chk("flush_start_stall_next", 32'(stall_req), 32'd0);
        chk("flush_start_done_next", 32'(done), 32'd0);
        @(negedge clk);
        #1;
        chk("flush_start_done_later", 32'(done), 32'd0);
        chk("flush_start_result", result, 32'd10);

        // flush during DONE: done still pulses.
        @(negedge clk);
        funct3 = 3'd5; op_a = 32'd5; op_b = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b1;
        #1;
        chk("flush_in_done_pulse", 32'(done), 32'd1);
        chk("flush_in_done_result", result, 32'hFFFF_FFFF);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_in_done_after", 32'(done), 32'd0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_stall", 32'(stall_req), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(3'd5, 32'd9, 32'd3, 32'd3, 33, 1'b1);

        // Randomised operations against the reference model, issued back-to-back.
        for (int n = 0; n < 40; n++) begin
            rf = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            do_op(rf, ra, rb, ref_res(rf, ra, rb), ref_lat(rf, ra, rb), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
